// File: rtl/rv_pkg.sv
// Shared RV32M multiply/divide definitions: funct3 encodings, FSM states and
// small decode helpers used by the iterative mul/div unit.
package rv_pkg;

    localparam int DEFAULT_WORD = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } md_state_e;

    function automatic logic op_is_div(input md_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic op_a_signed(input md_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_b_signed(input md_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring
// divide on magnitudes, sharing one 2*WORD accumulator and one adder.
module mul_div_unit
    import rv_pkg::*;
#(
    parameter int WORD = DEFAULT_WORD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [WORD-1:0] dataA_in,
    input  logic [WORD-1:0] dataB_in,
    output logic            busy,
    output logic            done,
    output logic [WORD-1:0] result
);

    localparam int CNT_W = $clog2(WORD);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD - 1);

    md_state_e         state_reg, state_next;
    logic [CNT_W-1:0]  counter_reg, counter_next;
    md_op_e            op_reg, op_next;
    logic [2*WORD-1:0] acc_reg, acc_next;
    logic [WORD-1:0]   opb_reg, opb_next;
    logic              neg_q_reg, neg_q_next;
    logic              neg_r_reg, neg_r_next;
    logic              b_zero_reg, b_zero_next;
    logic [WORD-1:0]   result_reg, result_next;

    logic [WORD-1:0]   hi, lo;
    logic [WORD+1:0]   add_a, add_b, sum;
    md_op_e            op_in;
    logic              a_neg, b_neg;
    logic [WORD-1:0]   a_mag, b_mag;
    logic [2*WORD-1:0] prod;
    logic [WORD-1:0]   quo, rem;

    assign hi    = acc_reg[2*WORD-1:WORD];
    assign lo    = acc_reg[WORD-1:0];
    assign op_in = md_op_e'(op);

    // Divide shifts the next dividend bit into the partial remainder before the
    // trial subtract; the extra top bit of the sum is the borrow.
    always_comb begin
        add_b = {2'b00, opb_reg};
        if (op_is_div(op_reg)) begin
            add_a = {1'b0, hi, lo[WORD-1]};
            sum   = add_a - add_b;
        end else begin
            add_a = {2'b00, hi};
            sum   = add_a + add_b;
        end
    end

    // Operand magnitudes; the most-negative value maps onto itself as an
    // unsigned WORD-bit magnitude, so nothing is lost.
    always_comb begin
        a_neg = op_a_signed(op_in) && dataA_in[WORD-1];
        b_neg = op_b_signed(op_in) && dataB_in[WORD-1];
        a_mag = a_neg ? -dataA_in : dataA_in;
        b_mag = b_neg ? -dataB_in : dataB_in;
    end

    always_comb begin
        prod = neg_q_reg ? -acc_reg : acc_reg;
        quo  = b_zero_reg ? '1 : (neg_q_reg ? -lo : lo);
        rem  = neg_r_reg ? -hi : hi;
    end

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        op_next      = op_reg;
        acc_next     = acc_reg;
        opb_next     = opb_reg;
        neg_q_next   = neg_q_reg;
        neg_r_next   = neg_r_reg;
        b_zero_next  = b_zero_reg;
        result_next  = result_reg;
        case (state_reg)
            IDLE: begin
                if (start && !flush) begin
                    op_next      = op_in;
                    acc_next     = {{WORD{1'b0}}, a_mag};
                    opb_next     = b_mag;
                    neg_q_next   = a_neg ^ b_neg;
                    neg_r_next   = a_neg;
                    b_zero_next  = (dataB_in == '0);
                    counter_next = '0;
                    state_next   = CALC;
                end
            end
            CALC: begin
                if (op_is_div(op_reg)) begin
                    if (!sum[WORD+1])
                        acc_next = {sum[WORD-1:0], lo[WORD-2:0], 1'b1};
                    else
                        acc_next = {hi[WORD-2:0], lo[WORD-1], lo[WORD-2:0], 1'b0};
                end else begin
                    acc_next = lo[0] ? {sum[WORD:0], lo[WORD-1:1]}
                                     : {1'b0, hi, lo[WORD-1:1]};
                end
                counter_next = counter_reg + CNT_W'(1);
                if (counter_reg == LAST)
                    state_next = FIX;
            end
            FIX: begin
                case (op_reg)
                    OP_MUL:                       result_next = prod[WORD-1:0];
                    OP_MULH, OP_MULHSU, OP_MULHU: result_next = prod[2*WORD-1:WORD];
                    OP_DIV, OP_DIVU:              result_next = quo;
                    default:                      result_next = rem;
                endcase
                state_next = DONE;
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // An abort wins over everything and never touches the visible result.
        if (flush) begin
            state_next  = IDLE;
            result_next = result_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            counter_reg <= '0;
            op_reg      <= OP_MUL;
            acc_reg     <= '0;
            opb_reg     <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            b_zero_reg  <= 1'b0;
            result_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            op_reg      <= op_next;
            acc_reg     <= acc_next;
            opb_reg     <= opb_next;
            neg_q_reg   <= neg_q_next;
            neg_r_reg   <= neg_r_next;
            b_zero_reg  <= b_zero_next;
            result_reg  <= result_next;
        end
    end

    assign busy   = (state_reg == CALC) || (state_reg == FIX);
    assign done   = (state_reg == DONE);
    assign result = result_reg;

endmodule
